// File: rtl/spi_responder_pkg.sv
// spi_responder_pkg
//   Shared constants and types for the SPI mode-0 responder.
//   SPI_IDLE_DEFAULT : byte shifted out when nothing is pending at a load point
//   SPI_BITCNT_W     : width of the bit-within-byte counter (wraps every 8 bits)
//   spi_byte_t       : one serial byte
//   tx_action_e      : what the tx shift register does on a given cycle
package spi_responder_pkg;

  localparam logic [7:0] SPI_IDLE_DEFAULT = 8'hFF;
  localparam int         SPI_BITCNT_W     = 3;

  typedef logic [7:0] spi_byte_t;

  typedef enum logic [1:0] {
    TX_HOLD,   // keep current contents
    TX_SHIFT,  // move next bit to the MSB
    TX_LOAD,   // byte slot boundary: take pending byte or the idle byte
    TX_IDLE    // transfer aborted: park on the idle byte
  } tx_action_e;

endpackage

// File: rtl/spi_responder_if.sv
// spi_responder_if
//   Bundles the SPI pins and the local host-side byte port of the responder.
//   SPI side : spi_cs_n, spi_clk, spi_di (into responder), spi_do (out)
//   RX side  : rx_data, rx_ready, rx_overrun (out), rx_ack (in)
//   TX side  : tx_data, tx_wr (in), tx_empty, tx_underrun (out)
//   Misc     : flag_clr (in), busy (out)
//   modport slave  - the responder's view
//   modport master - the view of whoever drives the pins and the host port
interface spi_responder_if;
  import spi_responder_pkg::*;

  logic      spi_cs_n;
  logic      spi_clk;
  logic      spi_di;
  logic      spi_do;
  spi_byte_t rx_data;
  logic      rx_ready;
  logic      rx_ack;
  logic      rx_overrun;
  spi_byte_t tx_data;
  logic      tx_wr;
  logic      tx_empty;
  logic      tx_underrun;
  logic      flag_clr;
  logic      busy;

  modport slave (
    input  spi_cs_n, spi_clk, spi_di, rx_ack, tx_data, tx_wr, flag_clr,
    output spi_do, rx_data, rx_ready, rx_overrun, tx_empty, tx_underrun, busy
  );

  modport master (
    output spi_cs_n, spi_clk, spi_di, rx_ack, tx_data, tx_wr, flag_clr,
    input  spi_do, rx_data, rx_ready, rx_overrun, tx_empty, tx_underrun, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Brings an asynchronous pin into the clk domain through STAGES flops and
//   produces registered one-cycle rise/fall pulses.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : asynchronous input pin
//   level      : synchronised level (last stage of the chain)
//   rise, fall : one-cycle pulses, one clk after the level changes
//   The chain resets to RESET_VAL so the pin's idle level produces no edge.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_chain
    if (gi == 0) begin : g_first
      assign chain_d[gi] = din;
    end else begin : g_rest
      assign chain_d[gi] = chain_q[gi-1];
    end
  end

  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    rise_d = chain_q[STAGES-1] & ~prev_q;
    fall_d = ~chain_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= chain_q[STAGES-1];
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = chain_q[STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_responder.sv
// spi_responder
//   SPI mode-0 target. Oversamples the SPI pins in the clk domain,
//   deserialises MOSI bytes into rx_data and serialises one tx byte per slot.
//   clk   : local clock; half SPI period must be >= SYNC_STAGES+3 clk periods
//   rst_n : synchronous active-low reset
//   bus   : spi_responder_if.slave (SPI pins + host byte port)
//   spi_do is registered from the MSB of the tx shifter and never tristated.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter spi_byte_t IDLE_BYTE   = SPI_IDLE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_responder_if.slave bus
);

  // Edge detection of the pins
  logic cs_level, cs_rise, cs_fall;
  logic sck_level_unused, sck_rise, sck_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.spi_clk),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // MOSI gets one extra stage so that, when the registered sck_rise pulse is
  // acted on, the last stage holds the value sampled alongside the sck edge.
  logic [SYNC_STAGES:0] di_chain_q, di_chain_d;
  logic                 di_sync;

  for (genvar gi = 0; gi <= SYNC_STAGES; gi++) begin : g_di
    if (gi == 0) begin : g_first
      assign di_chain_d[gi] = bus.spi_di;
    end else begin : g_rest
      assign di_chain_d[gi] = di_chain_q[gi-1];
    end
  end

  assign di_sync = di_chain_q[SYNC_STAGES];

  // State
  logic [SPI_BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  spi_byte_t               rx_shift_q, rx_shift_d;
  spi_byte_t               rx_data_q, rx_data_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    rx_overrun_q, rx_overrun_d;
  spi_byte_t               tx_shift_q, tx_shift_d;
  spi_byte_t               tx_buf_q, tx_buf_d;
  logic                    tx_pending_q, tx_pending_d;
  logic                    tx_underrun_q, tx_underrun_d;

  tx_action_e tx_act;
  logic       byte_done;
  spi_byte_t  rx_byte;

  always_comb begin
    bitcnt_d      = bitcnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_ready_d    = rx_ready_q;
    rx_overrun_d  = rx_overrun_q;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    tx_pending_d  = tx_pending_q;
    tx_underrun_d = tx_underrun_q;
    tx_act        = TX_HOLD;
    byte_done     = 1'b0;
    rx_byte       = {rx_shift_q[6:0], di_sync};

    // Framing: cs edges take priority; sck edges only count inside a frame.
    if (cs_rise) begin
      bitcnt_d   = '0;
      rx_shift_d = '0;
      tx_act     = TX_IDLE;
    end else if (cs_fall) begin
      bitcnt_d = '0;
      tx_act   = TX_LOAD;
    end else if (!cs_level) begin
      if (sck_rise) begin
        rx_shift_d = rx_byte;
        bitcnt_d   = bitcnt_q + 1'b1;
        byte_done  = (bitcnt_q == '1);
      end else if (sck_fall) begin
        // bitcnt back at zero means the previous byte just finished
        tx_act = (bitcnt_q == '0) ? TX_LOAD : TX_SHIFT;
      end
    end

    // Clear first so a flag set in the same cycle survives.
    if (bus.flag_clr) begin
      rx_overrun_d  = 1'b0;
      tx_underrun_d = 1'b0;
    end

    if (bus.rx_ack && rx_ready_q) begin
      rx_ready_d = 1'b0;
    end

    if (byte_done) begin
      rx_data_d  = rx_byte;
      rx_ready_d = 1'b1;
      // An ack landing with the new byte consumed the old one: no overrun.
      if (rx_ready_q && !bus.rx_ack) begin
        rx_overrun_d = 1'b1;
      end
    end

    unique case (tx_act)
      TX_SHIFT: tx_shift_d = {tx_shift_q[6:0], 1'b0};
      TX_IDLE:  tx_shift_d = IDLE_BYTE;
      TX_LOAD: begin
        if (tx_pending_q) begin
          tx_shift_d   = tx_buf_q;
          tx_pending_d = 1'b0;
        end else begin
          tx_shift_d    = IDLE_BYTE;
          tx_underrun_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Applied after the load so a coincident load sees the pre-write buffer
    // and the new byte waits for the next slot.
    if (bus.tx_wr) begin
      tx_buf_d     = bus.tx_data;
      tx_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      di_chain_q    <= '0;
      bitcnt_q      <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_ready_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_shift_q    <= IDLE_BYTE;
      tx_buf_q      <= '0;
      tx_pending_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      di_chain_q    <= di_chain_d;
      bitcnt_q      <= bitcnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_ready_q    <= rx_ready_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_pending_q  <= tx_pending_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign bus.spi_do      = tx_shift_q[7];
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_ready    = rx_ready_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_empty    = ~tx_pending_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.busy        = ~cs_level;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder
//   Directed bench: a mode-0 initiator model drives the SPI pins at clk
//   negedges and reads spi_do just before each sck rise. clk is ~28 MHz;
//   each sck phase lasts HALF clk periods, which keeps the SYNC_STAGES+3
//   half-period margin the responder needs.
module tb_spi_responder;

  localparam int HALF = 6;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   rdy_rises;
  logic rdy_prev;

  spi_responder_if bus ();

  spi_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #18 clk = ~clk;

  // Counts rx_ready rising edges, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_ready === 1'b1 && rdy_prev !== 1'b1) rdy_rises = rdy_rises + 1;
    rdy_prev = bus.rx_ready;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench still running at %0t, required finish before 2ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic pulse_ack();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] b);
    bus.tx_data = b;
    bus.tx_wr   = 1'b1;
    @(negedge clk);
    bus.tx_wr   = 1'b0;
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Shifts nbits of mosi (MSB first). With ack_last, rx_ack is held high for
  // exactly the clk edge that acts on the final sck rise (4th posedge after
  // the pin change).
  task automatic xfer(input logic [7:0] mosi, input int nbits, input bit ack_last,
                      output logic [7:0] miso);
    miso = '0;
    for (int k = 0; k < nbits; k++) begin
      bus.spi_di = mosi[7-k];
      repeat (HALF) @(negedge clk);
      miso[7-k]   = bus.spi_do;
      bus.spi_clk = 1'b1;
      if (ack_last && k == nbits - 1) begin
        repeat (3) @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    $display("xfer bits=%0d mosi=%02h miso=%02h rx_data=%02h rx_ready=%0b", nbits, mosi, miso,
             bus.rx_data, bus.rx_ready);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_di   = 1'b0;
    bus.rx_ack   = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_wr    = 1'b0;
    bus.flag_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.spi_do !== 1'b1) begin bad++; $display("FAIL reset_spi_do: got %b want 1", bus.spi_do); end
    total++; if (bus.tx_empty !== 1'b1) begin bad++; $display("FAIL reset_tx_empty: got %b want 1", bus.tx_empty); end
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b want 0", bus.rx_ready); end
    total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_rx_overrun: got %b want 0", bus.rx_overrun); end
    total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL reset_tx_underrun: got %b want 0", bus.tx_underrun); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %02h want 00", bus.rx_data); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] miso;
    write_tx(8'hA5);
    total++; if (bus.tx_empty !== 1'b0) begin bad++; $display("FAIL basic_tx_full: got %b want 0", bus.tx_empty); end
    cs_low();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    // A5 is already in the shifter; queue a byte for the slot after it so
    // the end-of-byte load point does not underrun.
    write_tx(8'h5A);
    xfer(8'h3C, 8, 1'b0, miso);
    total++; if (miso !== 8'hA5) begin bad++; $display("FAIL basic_miso: got %02h want a5", miso); end
    total++; if (bus.rx_data !== 8'h3C) begin bad++; $display("FAIL basic_rx_data: got %02h want 3c", bus.rx_data); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL basic_rx_ready: got %b want 1", bus.rx_ready); end
    total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL basic_tx_underrun: got %b want 0", bus.tx_underrun); end
    cs_high();
    total++; if (bus.tx_empty !== 1'b1) begin bad++; $display("FAIL basic_tx_empty_after: got %b want 1", bus.tx_empty); end
    total++; if (bus.spi_do !== 1'b1) begin bad++; $display("FAIL basic_spi_do_idle: got %b want 1", bus.spi_do); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_off: got %b want 0", bus.busy); end
  endtask

  task automatic test_two_bytes();
    logic [7:0] miso;
    pulse_ack();
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL two_ack_clears: got %b want 0", bus.rx_ready); end
    cs_low();
    xfer(8'h11, 8, 1'b0, miso);
    total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL two_no_overrun_yet: got %b want 0", bus.rx_overrun); end
    xfer(8'h22, 8, 1'b0, miso);
    cs_high();
    total++; if (bus.rx_data !== 8'h22) begin bad++; $display("FAIL two_rx_data: got %02h want 22", bus.rx_data); end
    total++; if (bus.rx_overrun !== 1'b1) begin bad++; $display("FAIL two_overrun: got %b want 1", bus.rx_overrun); end
    total++; if (bus.tx_underrun !== 1'b1) begin bad++; $display("FAIL two_underrun: got %b want 1", bus.tx_underrun); end
    pulse_clr();
    total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL two_clr_overrun: got %b want 0", bus.rx_overrun); end
    total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL two_clr_underrun: got %b want 0", bus.tx_underrun); end
  endtask

  task automatic test_underrun();
    logic [7:0] miso;
    pulse_ack();
    cs_low();
    xfer(8'h55, 8, 1'b0, miso);
    cs_high();
    total++; if (miso !== 8'hFF) begin bad++; $display("FAIL under_miso: got %02h want ff", miso); end
    total++; if (bus.tx_underrun !== 1'b1) begin bad++; $display("FAIL under_flag: got %b want 1", bus.tx_underrun); end
    total++; if (bus.rx_data !== 8'h55) begin bad++; $display("FAIL under_rx_data: got %02h want 55", bus.rx_data); end
    total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL under_overrun: got %b want 0", bus.rx_overrun); end
    pulse_clr();
  endtask

  task automatic test_abort();
    logic [7:0] miso;
    pulse_ack();
    rdy_rises = 0;
    cs_low();
    xfer(8'hE7, 5, 1'b0, miso);
    cs_high();
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL abort_no_ready: got %b want 0", bus.rx_ready); end
    total++; if (bus.rx_data !== 8'h55) begin bad++; $display("FAIL abort_rx_data_kept: got %02h want 55", bus.rx_data); end
    cs_low();
    xfer(8'h81, 8, 1'b0, miso);
    cs_high();
    total++; if (bus.rx_data !== 8'h81) begin bad++; $display("FAIL abort_rx_data: got %02h want 81", bus.rx_data); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL abort_rx_ready: got %b want 1", bus.rx_ready); end
    total++; if (rdy_rises !== 1) begin bad++; $display("FAIL abort_ready_rises: got %0d want 1", rdy_rises); end
    total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL abort_overrun: got %b want 0", bus.rx_overrun); end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic [7:0] miso_a;
    logic [7:0] miso_b;
    pulse_ack();
    total++; if (bus.tx_empty !== 1'b1) begin bad++; $display("FAIL b2b_start_empty: got %b want 1", bus.tx_empty); end
    total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL b2b_start_underrun: got %b want 0", bus.tx_underrun); end
    // tx_wr lands on the clk edge that acts on the cs fall (load point).
    bus.spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    write_tx(8'h6B);
    repeat (HALF - 4) @(negedge clk);
    xfer(8'hC3, 8, 1'b0, miso_a);
    total++; if (miso_a !== 8'hFF) begin bad++; $display("FAIL b2b_first_miso: got %02h want ff", miso_a); end
    total++; if (bus.tx_underrun !== 1'b1) begin bad++; $display("FAIL b2b_underrun: got %b want 1", bus.tx_underrun); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_a: got %b want 1", bus.rx_ready); end
    xfer(8'h96, 8, 1'b1, miso_b);
    cs_high();
    total++; if (miso_b !== 8'h6B) begin bad++; $display("FAIL b2b_second_miso: got %02h want 6b", miso_b); end
    total++; if (bus.rx_data !== 8'h96) begin bad++; $display("FAIL b2b_rx_data: got %02h want 96", bus.rx_data); end
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_kept: got %b want 1", bus.rx_ready); end
    total++; if (bus.rx_overrun !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun: got %b want 0", bus.rx_overrun); end
    total++; if (bus.tx_empty !== 1'b1) begin bad++; $display("FAIL b2b_end_empty: got %b want 1", bus.tx_empty); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rdy_rises = 0;
    rdy_prev  = 1'b0;
    test_reset();
    test_basic();
    test_two_bytes();
    test_underrun();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
